// File: rtl/onehot_pos_decoder.sv
// onehot_pos_decoder
// Converts a WIDTH-bit one-hot "lowest differing bit" mask back into a bit
// position by scanning CHUNK bits per cycle, with valid/ready handshakes on
// both sides. An all-zero mask is flagged through out_zero.
//
// Optional build macro: ONEHOT_CHECK_EN
//   defined   - every chunk is scanned (fixed WIDTH/CHUNK-cycle latency) and a
//               saturating set-bit count drives out_multi for multi-hot masks.
//   undefined - the scan stops at the chunk holding the lowest set bit, there
//               is no popcount logic and out_multi is tied to 0.
//
// WIDTH must be a multiple of CHUNK and IDX_W must equal clog2(WIDTH).

module onehot_pos_decoder #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_multi
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OFF_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [IDX_W-1:0]   pos_q, pos_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic               out_zero_q, out_zero_d;

  logic [CHUNK-1:0]   chunkBits;
  logic [IDX_W-1:0]   chunkBase;
  logic [OFF_W-1:0]   chunkOff;
  logic               chunkHit;
  logic [IDX_W-1:0]   chunkPos;
  logic               foundNow;
  logic [IDX_W-1:0]   posNow;
  logic               lastChunk;
  logic               exitNow;

`ifdef ONEHOT_CHECK_EN
  localparam int POP_W = $clog2(CHUNK + 1);
  localparam int SUM_W = POP_W + 1;

  logic [1:0]         popcnt_q, popcnt_d;
  logic               out_multi_q, out_multi_d;
  logic [POP_W-1:0]   chunkPop;
  logic [SUM_W-1:0]   popSum;
`endif

  // Select the chunk addressed by the counter and find its lowest set bit.
  always_comb begin
    chunkBits = '0;
    chunkBase = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (cnt_q == CNT_W'(c)) begin
        chunkBits = mask_q[c*CHUNK +: CHUNK];
        chunkBase = IDX_W'(c * CHUNK);
      end
    end
    chunkHit = 1'b0;
    chunkOff = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunkBits[i]) begin
        chunkHit = 1'b1;
        chunkOff = OFF_W'(i);
      end
    end
    chunkPos  = chunkBase + IDX_W'(chunkOff);
    foundNow  = found_q | chunkHit;
    posNow    = found_q ? pos_q : chunkPos;
    lastChunk = (cnt_q == CNT_W'(NCHUNK - 1));
`ifdef ONEHOT_CHECK_EN
    exitNow   = lastChunk;
`else
    exitNow   = lastChunk | chunkHit;
`endif
  end

`ifdef ONEHOT_CHECK_EN
  // Chunk popcount added to the running count, saturating at two.
  always_comb begin
    chunkPop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunkPop = chunkPop + POP_W'(chunkBits[i]);
    end
    popSum = SUM_W'(popcnt_q) + SUM_W'(chunkPop);
  end
`endif

  // Next-state and registered-output logic for the IDLE/SCAN/DONE handshake.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    found_d     = found_q;
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_zero_d  = out_zero_q;
`ifdef ONEHOT_CHECK_EN
    popcnt_d    = popcnt_q;
    out_multi_d = out_multi_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d  = in_mask;
          cnt_d   = '0;
          found_d = 1'b0;
          pos_d   = '0;
`ifdef ONEHOT_CHECK_EN
          popcnt_d = 2'd0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        found_d = foundNow;
        pos_d   = posNow;
`ifdef ONEHOT_CHECK_EN
        popcnt_d = (popSum >= SUM_W'(2)) ? 2'd2 : popSum[1:0];
`endif
        if (exitNow) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_idx_d   = foundNow ? posNow : '0;
          out_zero_d  = ~foundNow;
`ifdef ONEHOT_CHECK_EN
          out_multi_d = (popSum >= SUM_W'(2));
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_zero_q  <= 1'b0;
`ifdef ONEHOT_CHECK_EN
      popcnt_q    <= 2'd0;
      out_multi_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      found_q     <= found_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_zero_q  <= out_zero_d;
`ifdef ONEHOT_CHECK_EN
      popcnt_q    <= popcnt_d;
      out_multi_q <= out_multi_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_zero  = out_zero_q;
`ifdef ONEHOT_CHECK_EN
  assign out_multi = out_multi_q;
`else
  assign out_multi = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_pos_decoder.sv
// tb_onehot_pos_decoder
// Directed vectors with hand-computed results; the driver pushes expected
// responses into a queue and an independent monitor pops and compares them
// whenever the decoder raises out_valid. Honours ONEHOT_CHECK_EN.

module tb_onehot_pos_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_zero;
  logic        out_multi;

  typedef struct {
    logic [4:0] idx;
    logic       zero;
    logic       multi;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sbQ[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic       prevValid = 1'b0;
  logic [4:0] heldIdx   = '0;

  onehot_pos_decoder #(.WIDTH(32), .IDX_W(5), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_multi (out_multi)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Offer a mask, wait for acceptance and push the expected result.
  task automatic applyStimulus(input logic [31:0] mask, input logic [4:0] expIdx,
                               input logic expZero, input logic expMulti,
                               input int expLat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_mask  = mask;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e.idx   = expIdx;
      e.zero  = expZero;
      e.multi = expMulti;
      e.lat   = expLat;
      e.acc   = cyc;
      sbQ.push_back(e);
    end
  endtask

  // Wait until every pushed result has been seen and the decoder is idle.
  task automatic waitDrain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sbQ.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0 || !in_ready)
      checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
  endtask

  // Monitor: compare each new result with the scoreboard, and check that a
  // held result does not change while the consumer stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid && !prevValid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_result", {27'd0, out_idx}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("out_idx",   32'(out_idx),   32'(e.idx));
          checkOutput("out_zero",  32'(out_zero),  32'(e.zero));
          checkOutput("out_multi", 32'(out_multi), 32'(e.multi));
          checkOutput("latency",   32'(cyc - e.acc), 32'(e.lat));
        end
        heldIdx = out_idx;
      end else if (out_valid && prevValid) begin
        checkOutput("held_idx", 32'(out_idx), 32'(heldIdx));
      end
      prevValid = out_valid;
    end
  end

`ifdef ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Latency helper: full scan with the check build, otherwise the chunk of
  // the lowest set bit plus one.
  function automatic int latOf(input int earlyLat);
    return CHK ? 8 : earlyLat;
  endfunction

  // Directed test sequence.
  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_idx",   32'(out_idx),   32'd0);
    checkOutput("rst_out_zero",  32'(out_zero),  32'd0);
    checkOutput("rst_out_multi", 32'(out_multi), 32'd0);
    rst_n = 1'b1;

    applyStimulus(32'h0000_0001, 5'd0,  1'b0, 1'b0, latOf(1));
    waitDrain();
    applyStimulus(32'h8000_0000, 5'd31, 1'b0, 1'b0, 8);
    waitDrain();
    applyStimulus(32'h0000_0000, 5'd0,  1'b1, 1'b0, 8);
    waitDrain();
    applyStimulus(32'h0001_0100, 5'd8,  1'b0, CHK,  latOf(3));
    waitDrain();
    applyStimulus(32'h0000_0010, 5'd4,  1'b0, 1'b0, latOf(2));
    waitDrain();
    applyStimulus(32'hFFFF_FFFF, 5'd0,  1'b0, CHK,  latOf(1));
    waitDrain();
    applyStimulus(32'h4000_0000, 5'd30, 1'b0, 1'b0, 8);
    waitDrain();

    // Back-pressure: result must hold and a second mask must be ignored.
    out_ready = 1'b0;
    applyStimulus(32'h0000_0400, 5'd10, 1'b0, 1'b0, latOf(3));
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_reached", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_mask  = 32'h0000_0002;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_valid",    32'(out_valid), 32'd1);
      checkOutput("stall_idx",      32'(out_idx),   32'd10);
      checkOutput("stall_in_ready", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_valid",    32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready),  32'd1);
    applyStimulus(32'h0000_0002, 5'd1, 1'b0, 1'b0, latOf(1));
    waitDrain();

    // Reset three cycles into a scan discards it completely.
    @(negedge clk);
    in_valid = 1'b1;
    in_mask  = 32'h0010_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready",  32'(in_ready),  32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_out_idx",   32'(out_idx),   32'd0);
    checkOutput("abort_out_zero",  32'(out_zero),  32'd0);
    checkOutput("abort_out_multi", 32'(out_multi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(32'h0000_0020, 5'd5, 1'b0, 1'b0, latOf(2));
    waitDrain();

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
